// File: rtl/snp_width_pkg.sv
// Shared derivations and FSM encoding for the snooper-to-memory width adapter.
package snp_width_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_STALL   = 2'd2
    } adp_state_e;

    function automatic int calc_n(input int snp_addr_width, input int mem_addr_width);
        return snp_addr_width - mem_addr_width;
    endfunction

    function automatic int calc_ratio(input int n);
        return (n > 0) ? (1 << n) : 1;
    endfunction

    // Offset field width; kept at least one bit so RATIO=1 still has a legal vector.
    function automatic int calc_offw(input int n);
        return (n > 0) ? n : 1;
    endfunction

endpackage

// File: rtl/snp_seg_buffer.sv
// Accumulation buffer: per-segment data and valid bits plus the word tag being assembled.
module snp_seg_buffer #(
    parameter int SNP_WIDTH      = 32,
    parameter int RATIO          = 2,
    parameter int OFFW           = 1,
    parameter int MEM_ADDR_WIDTH = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr,
    input  logic                              fresh,
    input  logic                              clr,
    input  logic [OFFW-1:0]                   off,
    input  logic [MEM_ADDR_WIDTH-1:0]         word,
    input  logic [SNP_WIDTH-1:0]              seg_data,
    output logic [RATIO-1:0][SNP_WIDTH-1:0]   cur_data,
    output logic [RATIO-1:0]                  cur_valid,
    output logic [MEM_ADDR_WIDTH-1:0]         cur_tag,
    output logic [RATIO-1:0][SNP_WIDTH-1:0]   nxt_data,
    output logic [RATIO-1:0]                  nxt_valid
);

    // nxt_* is the buffer with this cycle's segment merged in; fresh drops the old word first.
    for (genvar k = 0; k < RATIO; k++) begin : g_seg
        logic hit;
        assign hit          = wr && (off == OFFW'(k));
        assign nxt_data[k]  = hit ? seg_data : cur_data[k];
        assign nxt_valid[k] = hit | (~fresh & cur_valid[k]);
    end

    // Clearing only drops valid bits; stale data lanes are masked at flush time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_data  <= '0;
            cur_valid <= '0;
            cur_tag   <= '0;
        end else if (clr) begin
            cur_valid <= '0;
        end else if (wr) begin
            cur_data  <= nxt_data;
            cur_valid <= nxt_valid;
            cur_tag   <= word;
        end
    end

endmodule

// File: rtl/snp_width_adapter.sv
// Packs narrow snooper segment writes into wide packet-memory words.
// Optional SNP_WIDTH_ADAPTER_WR_STRB_EN adds a per-segment write strobe output.
module snp_width_adapter
    import snp_width_pkg::*;
#(
    parameter int MEM_WIDTH      = 64,
    parameter int SNP_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 9,
    parameter int SNP_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SNP_ADDR_WIDTH-1:0] snp_addr,
    input  logic [SNP_WIDTH-1:0]      snp_wr_data,
    input  logic                      snp_wr_en,
    input  logic                      snp_done,
    output logic                      snp_rdy,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]      mem_wr_data,
    output logic                      mem_wr_en,
    output logic                      mem_done
`ifdef SNP_WIDTH_ADAPTER_WR_STRB_EN
    ,
    output logic [calc_ratio(calc_n(SNP_ADDR_WIDTH, MEM_ADDR_WIDTH))-1:0] mem_wr_strb
`endif
);

    localparam int N     = calc_n(SNP_ADDR_WIDTH, MEM_ADDR_WIDTH);
    localparam int RATIO = calc_ratio(N);
    localparam int OFFW  = calc_offw(N);

    if ((N < 0) || (MEM_WIDTH % SNP_WIDTH != 0) || (MEM_WIDTH / SNP_WIDTH != RATIO)) begin : g_bad_cfg
        $error("snp_width_adapter: MEM_WIDTH/SNP_WIDTH must equal 2**(SNP_ADDR_WIDTH-MEM_ADDR_WIDTH)");
    end

    adp_state_e                      state, state_d;
    logic                            pend_done, pend_done_d;
    logic [MEM_ADDR_WIDTH-1:0]       word;
    logic [OFFW-1:0]                 off;
    logic                            accept, last, switch_word;

    logic                            buf_wr, buf_fresh, buf_clr;
    logic [RATIO-1:0][SNP_WIDTH-1:0] cur_data, nxt_data, flush_data, out_data;
    logic [RATIO-1:0]                cur_valid, nxt_valid, flush_valid;
    logic [MEM_ADDR_WIDTH-1:0]       cur_tag, flush_addr;
    logic                            flush, flush_merged, done_d;

    assign word        = snp_addr[SNP_ADDR_WIDTH-1 -: MEM_ADDR_WIDTH];
    assign off         = (N > 0) ? snp_addr[OFFW-1:0] : '0;
    assign snp_rdy     = (state != ST_STALL);
    assign accept      = snp_wr_en && snp_rdy;
    assign last        = (off == OFFW'(RATIO - 1));
    assign switch_word = accept && (state == ST_PARTIAL) && (word != cur_tag);

    snp_seg_buffer #(
        .SNP_WIDTH      (SNP_WIDTH),
        .RATIO          (RATIO),
        .OFFW           (OFFW),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (buf_wr),
        .fresh     (buf_fresh),
        .clr       (buf_clr),
        .off       (off),
        .word      (word),
        .seg_data  (snp_wr_data),
        .cur_data  (cur_data),
        .cur_valid (cur_valid),
        .cur_tag   (cur_tag),
        .nxt_data  (nxt_data),
        .nxt_valid (nxt_valid)
    );

    always_comb begin
        state_d      = state;
        pend_done_d  = pend_done;
        buf_wr       = 1'b0;
        buf_fresh    = 1'b0;
        buf_clr      = 1'b0;
        flush        = 1'b0;
        flush_merged = 1'b0;
        flush_addr   = cur_tag;
        done_d       = 1'b0;
        case (state)
            ST_EMPTY, ST_PARTIAL: begin
                if (accept) begin
                    buf_wr    = 1'b1;
                    buf_fresh = switch_word;
                    if (switch_word) begin
                        // Old word goes out now; the new one may itself be complete and owe a flush.
                        flush   = 1'b1;
                        state_d = ST_PARTIAL;
                        if (last || snp_done) begin
                            state_d     = ST_STALL;
                            pend_done_d = snp_done;
                        end
                    end else if (last || snp_done) begin
                        flush        = 1'b1;
                        flush_merged = 1'b1;
                        flush_addr   = word;
                        buf_clr      = 1'b1;
                        done_d       = snp_done;
                        state_d      = ST_EMPTY;
                    end else begin
                        state_d = ST_PARTIAL;
                    end
                end else if (snp_done) begin
                    flush   = |cur_valid;
                    buf_clr = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_EMPTY;
                end
            end
            ST_STALL: begin
                flush       = 1'b1;
                buf_clr     = 1'b1;
                done_d      = pend_done;
                pend_done_d = 1'b0;
                state_d     = ST_EMPTY;
            end
            default: begin
                buf_clr     = 1'b1;
                pend_done_d = 1'b0;
                state_d     = ST_EMPTY;
            end
        endcase
    end

    assign flush_data  = flush_merged ? nxt_data  : cur_data;
    assign flush_valid = flush_merged ? nxt_valid : cur_valid;

    for (genvar k = 0; k < RATIO; k++) begin : g_mask
        assign out_data[k] = flush_valid[k] ? flush_data[k] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            pend_done   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_done    <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            state     <= state_d;
            pend_done <= pend_done_d;
            mem_wr_en <= flush;
            mem_done  <= done_d;
            if (flush) begin
                mem_addr    <= flush_addr;
                mem_wr_data <= out_data;
            end
        end
    end

`ifdef SNP_WIDTH_ADAPTER_WR_STRB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     mem_wr_strb <= '0;
        else if (flush) mem_wr_strb <= flush_valid;
    end
`endif

endmodule
